// File: rtl/cpu_run_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_run_ctrl
//   Run/step/halt sequencer for the soft CPU. Produces a single-cycle CPU
//   clock-enable in the iCLK domain, with the enable period selected from a
//   priority-encoded speed-switch bank. Also provides a debounced single-step
//   key, a CPU reset sequence and a saturating count of enable pulses.
//
// Ports
//   iCLK       in   1      system clock, all logic on its rising edge
//   iRST_n     in   1      synchronous active-low reset
//   iSPEED     in   NSEL   speed switches, highest set bit wins (0 = slowest)
//   iRUN       in   1      1 = free-run mode, 0 = single-step mode
//   iKEY_n     in   1      raw step push-button (active-low, async, bouncy)
//   iCLR       in   1      synchronous CPU clear request (level)
//   iHLT       in   1      CPU halt flag
//   oCPU_EN    out  1      one-cycle CPU clock-enable pulse (registered)
//   oCPU_RST   out  1      CPU reset, active-high
//   oCYCLES    out  CYC_W  enable pulses since last reset/clear, saturating
//   oSTATE     out  2      00 RESET, 01 RUN, 10 STEP, 11 HALTED
//   oTICK_LED  out  1      toggles on every enable pulse
// -----------------------------------------------------------------------------
module cpu_run_ctrl #(
    parameter int DIV_W     = 26,
    parameter int MIN_SHIFT = 16,
    parameter int NSEL      = 9,
    parameter int DEB_W     = 20,
    parameter int CYC_W     = 32,
    parameter int RST_LEN   = 4
) (
    input  logic             iCLK,
    input  logic             iRST_n,
    input  logic [NSEL-1:0]  iSPEED,
    input  logic             iRUN,
    input  logic             iKEY_n,
    input  logic             iCLR,
    input  logic             iHLT,
    output logic             oCPU_EN,
    output logic             oCPU_RST,
    output logic [CYC_W-1:0] oCYCLES,
    output logic [1:0]       oSTATE,
    output logic             oTICK_LED
);

    localparam int TAP_W  = $clog2(DIV_W);
    localparam int SEL_W  = $clog2(NSEL + 1);
    localparam int RCNT_W = (RST_LEN > 1) ? $clog2(RST_LEN) : 1;

    typedef enum logic [1:0] {
        ST_RESET  = 2'b00,
        ST_RUN    = 2'b01,
        ST_STEP   = 2'b10,
        ST_HALTED = 2'b11
    } state_t;

    // ------------------------------------------------------------------
    // Speed selection. any_above[k] is set when some switch at index >= k
    // is on, so the number of ones in any_above[NSEL-1:0] equals
    // (highest set index + 1), or 0 when no switch is on. That count maps
    // directly onto the tap: tap = MIN_SHIFT + NSEL - count.
    // ------------------------------------------------------------------
    logic [NSEL:0]      any_above;
    logic [SEL_W-1:0]   sel_ones;
    logic [TAP_W-1:0]   tap;
    logic [DIV_W-1:0]   tap_mask;
    logic [DIV_W-1:0]   prescaler_reg;
    logic               tick;

    assign any_above[NSEL] = 1'b0;

    generate
        for (genvar gi = 0; gi < NSEL; gi++) begin : g_prio
            assign any_above[gi] = any_above[gi+1] | iSPEED[gi];
        end
    endgenerate

    always_comb begin
        sel_ones = '0;
        for (int j = 0; j < NSEL; j++) begin
            sel_ones = sel_ones + SEL_W'(any_above[j]);
        end
    end

    assign tap = TAP_W'(MIN_SHIFT + NSEL) - TAP_W'(sel_ones);

    // Mask covering prescaler bits [tap:0]
    generate
        for (genvar gi = 0; gi < DIV_W; gi++) begin : g_mask
            assign tap_mask[gi] = (TAP_W'(gi) <= tap);
        end
    endgenerate

    assign tick = &(prescaler_reg | ~tap_mask);

    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            prescaler_reg <= '0;
        end else begin
            prescaler_reg <= prescaler_reg + DIV_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Step key: two-flop synchronizer followed by a debouncer. The counter
    // tracks how long the synchronized level has disagreed with the
    // debounced level; it flips only after 2^DEB_W consecutive disagreeing
    // cycles. A press is the cycle in which the level flips to 0.
    // ------------------------------------------------------------------
    logic             key_meta_reg;
    logic             key_sync_reg;
    logic             deb_level_reg;
    logic [DEB_W-1:0] deb_cnt_reg;
    logic             deb_flip;
    logic             press;

    assign deb_flip = (key_sync_reg != deb_level_reg) && (&deb_cnt_reg);
    assign press    = deb_flip && !key_sync_reg;

    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            key_meta_reg  <= 1'b1;
            key_sync_reg  <= 1'b1;
            deb_level_reg <= 1'b1;
            deb_cnt_reg   <= '0;
        end else begin
            key_meta_reg <= iKEY_n;
            key_sync_reg <= key_meta_reg;
            if (key_sync_reg == deb_level_reg) begin
                deb_cnt_reg <= '0;
            end else if (deb_flip) begin
                deb_level_reg <= key_sync_reg;
                deb_cnt_reg   <= '0;
            end else begin
                deb_cnt_reg <= deb_cnt_reg + DEB_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    state_t            state_reg, state_next;
    logic [RCNT_W-1:0] rst_cnt_reg, rst_cnt_next;
    logic              en_reg, en_next;
    logic [CYC_W-1:0]  cycles_reg, cycles_next;
    logic              led_reg;

    // State register
    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            state_reg   <= ST_RESET;
            rst_cnt_reg <= '0;
            en_reg      <= 1'b0;
            cycles_reg  <= '0;
            led_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            rst_cnt_reg <= rst_cnt_next;
            en_reg      <= en_next;
            cycles_reg  <= cycles_next;
            led_reg     <= led_reg ^ en_next;
        end
    end

    // Next-state logic. A clear overrides everything below reset; halt and
    // mode changes take the cycle, so a same-cycle tick or press is dropped.
    always_comb begin
        state_next   = state_reg;
        rst_cnt_next = rst_cnt_reg;
        en_next      = 1'b0;
        if (iCLR) begin
            state_next   = ST_RESET;
            rst_cnt_next = '0;
        end else begin
            unique case (state_reg)
                ST_RESET: begin
                    if (rst_cnt_reg == RCNT_W'(RST_LEN - 1)) begin
                        state_next   = iRUN ? ST_RUN : ST_STEP;
                        rst_cnt_next = '0;
                    end else begin
                        rst_cnt_next = rst_cnt_reg + RCNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (iHLT)       state_next = ST_HALTED;
                    else if (!iRUN) state_next = ST_STEP;
                    else            en_next    = tick;
                end
                ST_STEP: begin
                    if (iHLT)      state_next = ST_HALTED;
                    else if (iRUN) state_next = ST_RUN;
                    else           en_next    = press;
                end
                default: begin
                    state_next = ST_HALTED;
                end
            endcase
        end

        // Counter advances on the edge that registers the pulse, so the new
        // value appears together with oCPU_EN.
        if (iCLR) begin
            cycles_next = '0;
        end else if (en_next && !(&cycles_reg)) begin
            cycles_next = cycles_reg + CYC_W'(1);
        end else begin
            cycles_next = cycles_reg;
        end
    end

    // Output logic
    always_comb begin
        oCPU_RST  = (state_reg == ST_RESET);
        oSTATE    = state_reg;
        oCPU_EN   = en_reg;
        oCYCLES   = cycles_reg;
        oTICK_LED = led_reg;
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
module tb_cpu_run_ctrl;

    localparam int DIV_W     = 12;
    localparam int MIN_SHIFT = 2;
    localparam int NSEL      = 9;
    localparam int DEB_W     = 3;
    localparam int RST_LEN   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n, run, key_n, clr, hlt;
    logic [NSEL-1:0] speed;

    logic        en, cpu_rst, led;
    logic [31:0] cycles;
    logic [1:0]  state;
    logic        s_en, s_rst, s_led;
    logic [3:0]  s_cycles;
    logic [1:0]  s_state;

    cpu_run_ctrl #(.DIV_W(DIV_W), .MIN_SHIFT(MIN_SHIFT), .NSEL(NSEL), .DEB_W(DEB_W),
                   .CYC_W(32), .RST_LEN(RST_LEN)) dut (
        .iCLK(clk), .iRST_n(rst_n), .iSPEED(speed), .iRUN(run), .iKEY_n(key_n),
        .iCLR(clr), .iHLT(hlt), .oCPU_EN(en), .oCPU_RST(cpu_rst), .oCYCLES(cycles),
        .oSTATE(state), .oTICK_LED(led)
    );

    // Narrow-counter instance fed with identical stimulus for saturation
    cpu_run_ctrl #(.DIV_W(DIV_W), .MIN_SHIFT(MIN_SHIFT), .NSEL(NSEL), .DEB_W(DEB_W),
                   .CYC_W(4), .RST_LEN(RST_LEN)) dut_sat (
        .iCLK(clk), .iRST_n(rst_n), .iSPEED(speed), .iRUN(run), .iKEY_n(key_n),
        .iCLR(clr), .iHLT(hlt), .oCPU_EN(s_en), .oCPU_RST(s_rst), .oCYCLES(s_cycles),
        .oSTATE(s_state), .oTICK_LED(s_led)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    // States use the externally visible codes: 0 RESET, 1 RUN, 2 STEP, 3 HALTED
    int     m_state, m_rlen, m_psc, m_diff_run;
    longint m_cyc;
    bit     m_en, m_led, m_deb, m_valid = 1'b0;
    bit     key_hist[$];   // synchronizer contents: [0] oldest (synchronized level)

    function automatic int period_of(logic [NSEL-1:0] sp);
        int k = -1;
        for (int i = 0; i < NSEL; i++) if (sp[i]) k = i;
        if (k < 0) return 1 << (MIN_SHIFT + NSEL + 1);
        return 1 << (MIN_SHIFT + NSEL - k);
    endfunction

    function automatic bit model_tick_now();
        int per = period_of(speed);
        return (m_psc % per) == per - 1;
    endfunction

    task automatic model_step();
        bit tick_v, press_v, sync_v;
        tick_v  = model_tick_now();
        press_v = 1'b0;
        if (!rst_n) begin
            m_valid = 1'b1;
            m_state = 0; m_rlen = 0; m_psc = 0; m_diff_run = 0;
            m_cyc = 0; m_en = 0; m_led = 0; m_deb = 1;
            key_hist.delete();
            key_hist.push_back(1'b1);
            key_hist.push_back(1'b1);
            return;
        end
        sync_v = key_hist[0];
        if (sync_v != m_deb) begin
            m_diff_run++;
            if (m_diff_run == (1 << DEB_W)) begin
                m_deb = sync_v;
                m_diff_run = 0;
                press_v = (sync_v == 1'b0);
            end
        end else begin
            m_diff_run = 0;
        end
        void'(key_hist.pop_front());
        key_hist.push_back(key_n);
        m_psc = (m_psc + 1) % (1 << DIV_W);
        m_en = 1'b0;
        if (clr) begin
            m_state = 0; m_rlen = 0; m_cyc = 0;
        end else begin
            case (m_state)
                0: begin
                    m_rlen++;
                    if (m_rlen == RST_LEN) m_state = run ? 1 : 2;
                end
                1: if (hlt) m_state = 3; else if (!run) m_state = 2; else m_en = tick_v;
                2: if (hlt) m_state = 3; else if (run) m_state = 1; else m_en = press_v;
                default: ;
            endcase
        end
        if (m_en) begin
            m_led = ~m_led;
            if (m_cyc < 64'hFFFF_FFFF) m_cyc++;
        end
    endtask

    task automatic check(string name, longint act, longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
            if (errors >= 50) begin
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        end
    endtask

    task automatic tick_clk();
        @(posedge clk);
        model_step();
        #1;
        if (m_valid) begin
            check("en", en, m_en);
            check("rst", cpu_rst, (m_state == 0));
            check("state", state, m_state);
            check("cycles", cycles, m_cyc);
            check("led", led, m_led);
            check("sat_cycles", s_cycles, (m_cyc > 15) ? 15 : m_cyc);
            check("sat_led", s_led, m_led);
        end
    endtask

    // Interval between two consecutive pulses, measured after the current
    // speed setting has been in force for at least one edge.
    task automatic measure(string name, int exp);
        int lim, i, c, gap;
        lim = 3 * exp + 20;
        gap = -1;
        tick_clk();
        i = 0;
        while (!en && i < lim) begin tick_clk(); i++; end
        if (en) begin
            c = 0;
            do begin tick_clk(); c++; end while (!en && c < lim);
            if (en) gap = c;
        end
        check(name, gap, exp);
    endtask

    // Bouncy step press: 6 toggling cycles, 12 low, then released for 20
    task automatic press_seq(output int pulses);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            key_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick_clk(); if (en) pulses++;
        end
        key_n = 1'b0;
        for (int i = 0; i < 12; i++) begin tick_clk(); if (en) pulses++; end
        key_n = 1'b1;
        for (int i = 0; i < 20; i++) begin tick_clk(); if (en) pulses++; end
    endtask

    typedef struct {
        bit rst_n, clr, hlt, run;
        int ncyc;
        int exp_state;
        bit exp_rst;
        int exp_cyc;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int n, p, tog, i, hold;
        longint c0;
        bit prev;

        // {rst_n, clr, hlt, run, cycles, state, rst, count}
        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b1,  3, 0, 1'b1, 0};  // reset held
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1,  4, 1, 1'b0, 0};  // RST_LEN later -> RUN
        tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b1,  4, 1, 1'b0, 1};  // first tick at prescaler 7
        tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b1,  1, 3, 1'b0, 1};  // halt
        tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 20, 3, 1'b0, 1};  // halt is sticky
        tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0,  2, 0, 1'b1, 0};  // clear
        tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b0,  4, 2, 1'b0, 0};  // -> STEP
        tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b1,  1, 1, 1'b0, 0};  // STEP -> RUN
        tbl[8] = '{1'b0, 1'b1, 1'b1, 1'b1,  1, 0, 1'b1, 0};  // reset beats all

        rst_n = 1'b0; clr = 1'b0; hlt = 1'b0; run = 1'b1; key_n = 1'b1; speed = 9'h100;

        foreach (tbl[k]) begin
            rst_n = tbl[k].rst_n; clr = tbl[k].clr; hlt = tbl[k].hlt; run = tbl[k].run;
            for (int c = 0; c < tbl[k].ncyc; c++) tick_clk();
            $display("vec %0d: state=%0d rst=%0d cycles=%0d", k, state, cpu_rst, cycles);
            check("tbl_state", state, tbl[k].exp_state);
            check("tbl_rst", cpu_rst, tbl[k].exp_rst);
            check("tbl_cycles", cycles, tbl[k].exp_cyc);
        end

        // Reset release: oCPU_RST lasts exactly RST_LEN cycles afterwards
        rst_n = 1'b1; clr = 1'b0; hlt = 1'b0; run = 1'b1;
        n = 0;
        for (int c = 0; c < 12; c++) begin if (cpu_rst) n++; tick_clk(); end
        $display("reset release: rst cycles=%0d state=%0d", n, state);
        check("rst_len", n, RST_LEN);
        check("run_after_rst", state, 1);

        // RUN at the fastest speed: 10 pulses -> count 10
        rst_n = 1'b0; tick_clk(); rst_n = 1'b1;
        p = 0; i = 0;
        while (p < 10 && i < 200) begin tick_clk(); if (en) p++; i++; end
        $display("run: pulses=%0d cycles=%0d", p, cycles);
        check("pulses10", p, 10);
        check("cycles10", cycles, 10);
        check("sat10", s_cycles, 10);

        measure("period_100", 8);
        speed = 9'h101; measure("period_101", 8);
        speed = 9'h000; measure("period_000", 4096);   // tap = MIN_SHIFT+NSEL = 11
        speed = 9'h001; measure("period_001", 2048);
        speed = 9'h100; measure("period_back", 8);
        $display("periods measured");

        // STEP: bouncy key gives exactly one pulse per press
        run = 1'b0; tick_clk(); tick_clk();
        c0 = m_cyc;
        press_seq(p);
        $display("step press 1: pulses=%0d cycles=%0d", p, cycles);
        check("step1_pulses", p, 1);
        check("step1_cycles", cycles, c0 + 1);
        press_seq(p);
        $display("step press 2: pulses=%0d cycles=%0d", p, cycles);
        check("step2_pulses", p, 1);
        check("step2_cycles", cycles, c0 + 2);

        // Halt on a tick cycle: no pulse, frozen for 500 cycles
        run = 1'b1; tick_clk();
        i = 0;
        while (!(m_state == 1 && model_tick_now()) && i < 100) begin tick_clk(); i++; end
        c0 = m_cyc;
        hlt = 1'b1; tick_clk(); hlt = 1'b0;
        check("halt_no_en", en, 0);
        check("halt_state", state, 3);
        check("halt_cycles", cycles, c0);
        p = 0;
        for (int c = 0; c < 500; c++) begin
            key_n = ((c % 40) < 15) ? 1'b0 : 1'b1;
            tick_clk(); if (en) p++;
        end
        key_n = 1'b1;
        $display("halted: pulses=%0d cycles=%0d state=%0d", p, cycles, state);
        check("halt_pulses", p, 0);
        check("halt_frozen", cycles, c0);
        check("halt_stays", state, 3);

        // Clear together with halt from HALTED
        clr = 1'b1; hlt = 1'b1; tick_clk(); clr = 1'b0; hlt = 1'b0;
        check("clr_state", state, 0);
        check("clr_cycles", cycles, 0);
        n = 0; p = 0; tog = 0; prev = s_led;
        for (int c = 0; c < 10; c++) begin
            if (cpu_rst) n++;
            tick_clk();
            if (en) p++;
            if (s_led != prev) tog++;
            prev = s_led;
        end
        $display("clear: rst cycles=%0d state=%0d", n, state);
        check("clr_rst_len", n, RST_LEN);
        check("clr_to_run", state, 1);

        // Saturation of the 4-bit counter over 20 pulses
        i = 0;
        while (p < 20 && i < 400) begin
            tick_clk();
            if (en) p++;
            if (s_led != prev) tog++;
            prev = s_led;
            i++;
        end
        $display("saturation: pulses=%0d wide=%0d narrow=%0d toggles=%0d", p, cycles, s_cycles, tog);
        check("sat_pulses", p, 20);
        check("sat_wide", cycles, 20);
        check("sat_narrow", s_cycles, 15);
        check("sat_toggles", tog, 20);

        // Randomized stimulus against the model
        hold = 0;
        for (int c = 0; c < 6000; c++) begin
            if (hold == 0) begin
                key_n = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 14);
            end else begin
                hold--;
            end
            rst_n = ($urandom_range(0, 999) != 0);
            clr   = ($urandom_range(0, 299) == 0);
            hlt   = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 99) == 0) run = ~run;
            if ($urandom_range(0, 149) == 0)
                speed = 9'($urandom_range(0, 511)) | (($urandom_range(0, 1) != 0) ? 9'h100 : 9'h000);
            tick_clk();
        end
        $display("random: done, model cycles=%0d", m_cyc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
